// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH clocks per add.
// start/busy/done handshake; DONE can accept the next start with no idle gap.
module bit_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rega, regb, psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bitv, cnext;

    assign bitv  = rega[0] ^ regb[0] ^ carry;
    assign cnext = (rega[0] & regb[0]) | (rega[0] & carry) | (regb[0] & carry);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rega  <= '0;
            regb  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rega  <= a;
                        regb  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rega  <= rega >> 1;
                    regb  <= regb >> 1;
                    carry <= cnext;
                    psum  <= {bitv, psum[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    // On the MSB step, carry still holds the carry into the MSB.
                    if (cnt == LAST) begin
                        sum   <= {bitv, psum[WIDTH-1:1]};
                        cout  <= cnext;
                        ovf   <= carry ^ cnext;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: WIDTH=4 directed cases and WIDTH=8 random ops against an arithmetic model.
module tb_bit_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       st4, st8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       ci4, ci8;
    logic       busy4, done4, cout4, ovf4;
    logic       busy8, done8, cout8, ovf8;
    logic [3:0] sum4;
    logic [7:0] sum8;

    int nchk = 0;
    int nerr = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

    bit_serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted op keeps busy for w cycles, then one done cycle with the arithmetic result.
    int         left  [2];
    bit         mdone [2];
    longint     pend  [2];
    bit         povf  [2];
    longint     esum  [2];
    bit         ecout [2];
    bit         eovf  [2];

    task automatic mstep(input int id, input int w, input logic s,
                         input logic [7:0] a, input logic [7:0] b, input logic c);
        longint full, sa, sb, tot, lim;
        if (rst) begin
            left[id] = 0; mdone[id] = 0; esum[id] = 0; ecout[id] = 0; eovf[id] = 0;
        end else if (left[id] > 0) begin
            left[id]--;
            if (left[id] == 0) begin
                mdone[id] = 1;
                esum[id]  = pend[id] % (64'sd1 << w);
                ecout[id] = (pend[id] >= (64'sd1 << w));
                eovf[id]  = povf[id];
            end
        end else begin
            mdone[id] = 0;
            if (s) begin
                left[id] = w;
                full     = longint'(a) + longint'(b) + longint'(c);
                pend[id] = full;
                lim = 64'sd1 << (w - 1);
                sa  = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
                sb  = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
                tot = sa + sb + longint'(c);
                povf[id] = (tot >= lim) || (tot < -lim);
            end
        end
    endtask

    always @(posedge clk) begin
        mstep(0, 4, st4, {4'b0, a4}, {4'b0, b4}, ci4);
        mstep(1, 8, st8, a8, b8, ci8);
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("w4_outputs", {busy4, done4, cout4, ovf4, sum4},
                {left[0] > 0, mdone[0], ecout[0], eovf[0], esum[0][3:0]});
            chk("w8_outputs", {busy8, done8, cout8, ovf8, sum8},
                {left[1] > 0, mdone[1], ecout[1], eovf[1], esum[1][7:0]});
        end
    end

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] xs, input logic xc, input logic xo);
        int n = 0, bc = 0;
        @(negedge clk); st4 = 1; a4 = a; b4 = b; ci4 = c;
        @(negedge clk); st4 = 0; a4 = $urandom; b4 = $urandom;
        while (!done4 && n < 20) begin
            if (busy4) bc++;
            @(negedge clk); n++;
        end
        chk("w4_done_seen", done4, 1);
        chk("w4_busy_width", bc, 4);
        chk("w4_sum", sum4, xs);
        chk("w4_cout", cout4, xc);
        chk("w4_ovf", ovf4, xo);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0, bc = 0;
        longint full;
        @(negedge clk); st8 = 1; a8 = a; b8 = b; ci8 = c;
        @(negedge clk);
        while (!done8 && n < 40) begin
            if (busy8) bc++;
            st8 = 1'($urandom); a8 = $urandom; b8 = $urandom; ci8 = 1'($urandom);
            @(negedge clk); n++;
        end
        st8 = 0;
        full = longint'(a) + longint'(b) + longint'(c);
        chk("w8_done_seen", done8, 1);
        chk("w8_busy_width", bc, 8);
        chk("w8_sb_sum", {cout8, sum8}, full);
    endtask

    initial begin
        int n, dcnt;
        rst = 1; st4 = 0; st8 = 0; a4 = 0; b4 = 0; ci4 = 0; a8 = 0; b8 = 0; ci8 = 0;
        @(negedge clk);
        armed = 1;
        @(negedge clk);
        chk("reset_w4", {busy4, done4, cout4, ovf4, sum4}, 0);
        chk("reset_w8", {busy8, done8, cout8, ovf8, sum8}, 0);
        rst = 0;

        op4(4'b1111, 4'b0011, 0, 4'b0010, 1, 0);
        op4(4'b0111, 4'b0001, 0, 4'b1000, 0, 1);
        op4(4'b1000, 4'b1000, 0, 4'b0000, 1, 1);
        op4(4'b0000, 4'b0000, 1, 4'b0001, 0, 0);
        op4(4'b1111, 4'b0000, 1, 4'b0000, 1, 0);

        // Back-to-back 2+3 then 5+6, with ignored start pulses during RUN.
        @(negedge clk); st4 = 1; a4 = 2; b4 = 3; ci4 = 0;
        @(negedge clk); st4 = 0;
        @(negedge clk); st4 = 1; a4 = 15; b4 = 15; ci4 = 1;
        @(negedge clk); st4 = 0;
        @(negedge clk); st4 = 1; a4 = 5; b4 = 6; ci4 = 0;
        @(negedge clk);
        chk("b2b_first_done", done4, 1);
        chk("b2b_first_sum", sum4, 5);
        @(negedge clk);
        chk("b2b_no_gap_busy", busy4, 1);
        st4 = 1; a4 = 9; b4 = 9; ci4 = 1;
        @(negedge clk); st4 = 0;
        n = 0;
        while (!done4 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_second_done", done4, 1);
        chk("b2b_second_sum", sum4, 4'b1011);

        // Reset two RUN cycles into 9+4.
        @(negedge clk); st4 = 1; a4 = 9; b4 = 4; ci4 = 0;
        @(negedge clk); st4 = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("abort_outputs", {busy4, done4, cout4, ovf4, sum4}, 0);
        dcnt = 0;
        repeat (8) begin @(negedge clk); if (done4) dcnt++; end
        chk("abort_no_done", dcnt, 0);
        op4(4'b0001, 4'b0001, 0, 4'b0010, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        op8(8'hff, 8'hff, 1);
        op8(8'h7f, 8'h00, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
